// File: rtl/send_scheduler.sv
// send_scheduler: round-robin packet-start scheduler driving per-port send_module generators
module send_scheduler #(
    parameter int          PORT_NUB_TOTAL = 16,
    parameter int          WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
    parameter int          WIDTH_PRIORITY = 3,
    parameter int          WIDTH_LENGTH   = 10,
    parameter int          LEN_MIN        = 16,
    parameter int          LEN_RAND_BITS  = 5,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     go_i,
    input  logic                                     abort_i,
    input  logic [15:0]                              cfg_pkt_total_i,
    input  logic [WIDTH_PRIORITY-1:0]                cfg_priority_i,
    input  logic                                     full_i,
    input  logic                                     alm_ost_full_i,
    input  logic [PORT_NUB_TOTAL-1:0]                send_ready_i,
    input  logic [PORT_NUB_TOTAL-1:0]                send_done_i,
    output logic [PORT_NUB_TOTAL-1:0]                send_start_o,
    output logic [PORT_NUB_TOTAL*WIDTH_SEL-1:0]      send_dest_o,
    output logic [PORT_NUB_TOTAL*WIDTH_PRIORITY-1:0] send_priority_o,
    output logic [PORT_NUB_TOTAL*WIDTH_LENGTH-1:0]   send_length_o,
    output logic [15:0]                              issued_cnt_o,
    output logic [15:0]                              outstanding_o,
    output logic                                     busy_o,
    output logic                                     finished_o
);
    localparam int          N        = PORT_NUB_TOTAL;
    localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                            state_q, state_d;
    logic [15:0]                       total_q, issued_q, issued_d, outstanding_q, outstanding_d, lfsr_q;
    logic [WIDTH_PRIORITY-1:0]         prio_q;
    logic [N-1:0]                      pending_q, pending_d, start_q, elig, gnt_onehot;
    logic [WIDTH_SEL-1:0]              rr_q, gnt_idx, scan_idx, rnd_dest, new_dest;
    logic [WIDTH_LENGTH-1:0]           new_len;
    logic [N*WIDTH_SEL-1:0]            dest_q;
    logic [N*WIDTH_PRIORITY-1:0]       prio_field_q;
    logic [N*WIDTH_LENGTH-1:0]         len_q;
    logic                              gnt_found, grant, start_go;

    // first eligible port at or after rr_q, wrapping; grant only when RUN is unthrottled and quota remains
    always_comb begin
        elig      = send_ready_i & ~pending_q;
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        scan_idx  = rr_q;
        for (int k = 0; k < N; k++) begin
            scan_idx = rr_q + WIDTH_SEL'(k);
            if (!gnt_found && elig[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
        grant      = (state_q == RUN) && !abort_i && !full_i && !alm_ost_full_i && (issued_q < total_q) && gnt_found;
        gnt_onehot = grant ? (N'(1) << gnt_idx) : '0;
        rnd_dest   = lfsr_q[WIDTH_SEL-1:0];
        new_dest   = (rnd_dest == gnt_idx) ? gnt_idx + WIDTH_SEL'(1) : rnd_dest;
        new_len    = WIDTH_LENGTH'(LEN_MIN) + WIDTH_LENGTH'(lfsr_q[15 -: LEN_RAND_BITS]);
        start_go   = go_i && !abort_i && (state_q == IDLE || state_q == DONE);
        issued_d   = start_go ? 16'd0 : issued_q + 16'(grant);
        pending_d  = (pending_q & ~send_done_i) | gnt_onehot;
        // only dones from pending ports count, so the counter cannot underflow
        outstanding_d = outstanding_q + 16'(grant) - 16'($countones(send_done_i & pending_q));
    end

    // next-state decode; abort overrides everything including go
    always_comb begin
        state_d = state_q;
        if (abort_i) state_d = IDLE;
        else case (state_q)
            IDLE, DONE: if (go_i) state_d = (cfg_pkt_total_i == 16'd0) ? DRAIN : RUN;
            RUN:        if (issued_d >= total_q) state_d = DRAIN;
            DRAIN:      if (outstanding_q == 16'd0) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // state, counters, LFSR and per-port command fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            total_q       <= '0;
            prio_q        <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            pending_q     <= '0;
            start_q       <= '0;
            rr_q          <= '0;
            lfsr_q        <= SEED_EFF;
            dest_q        <= '0;
            prio_field_q  <= '0;
            len_q         <= '0;
        end else begin
            state_q       <= state_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            pending_q     <= pending_d;
            start_q       <= gnt_onehot;
            if (start_go) begin
                total_q <= cfg_pkt_total_i;
                prio_q  <= cfg_priority_i;
            end
            if (grant) begin
                rr_q   <= gnt_idx + WIDTH_SEL'(1);
                lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
                dest_q[gnt_idx*WIDTH_SEL +: WIDTH_SEL]                <= new_dest;
                prio_field_q[gnt_idx*WIDTH_PRIORITY +: WIDTH_PRIORITY] <= prio_q;
                len_q[gnt_idx*WIDTH_LENGTH +: WIDTH_LENGTH]           <= new_len;
            end
        end
    end

    assign send_start_o    = start_q;
    assign send_dest_o     = dest_q;
    assign send_priority_o = prio_field_q;
    assign send_length_o   = len_q;
    assign issued_cnt_o    = issued_q;
    assign outstanding_o   = outstanding_q;
    assign busy_o          = (state_q == RUN) || (state_q == DRAIN);
    assign finished_o      = (state_q == DONE);
endmodule

// File: tb/tb_send_scheduler.sv
// tb_send_scheduler: scoreboard and vector-table bench for send_scheduler
module tb_send_scheduler;
    localparam int N = 16, WS = 4, WP = 3, WL = 10;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            go = 1'b0, abort = 1'b0, full = 1'b0, alm = 1'b0;
    logic [15:0]     cfg_total = '0;
    logic [WP-1:0]   cfg_prio = '0;
    logic [N-1:0]    ready = '0, auto_done_v = '0, man_done = '0, send_done;
    logic [N-1:0]    send_start;
    logic [N*WS-1:0] send_dest;
    logic [N*WP-1:0] send_prio;
    logic [N*WL-1:0] send_len;
    logic [15:0]     issued, outstanding;
    logic            busy, finished;

    assign send_done = auto_done_v | man_done;
    always #5 clk = ~clk;

    send_scheduler dut (
        .clk(clk), .rst_n(rst_n), .go_i(go), .abort_i(abort),
        .cfg_pkt_total_i(cfg_total), .cfg_priority_i(cfg_prio),
        .full_i(full), .alm_ost_full_i(alm),
        .send_ready_i(ready), .send_done_i(send_done),
        .send_start_o(send_start), .send_dest_o(send_dest),
        .send_priority_o(send_prio), .send_length_o(send_len),
        .issued_cnt_o(issued), .outstanding_o(outstanding),
        .busy_o(busy), .finished_o(finished)
    );

    typedef struct { int port; int dest; int len; int prio; } exp_t;
    typedef struct { logic [15:0] total; logic [2:0] prio; logic [15:0] ready; int dly; int max_cyc; int span; } vec_t;

    exp_t        sb[$];
    vec_t        vecs[4];
    int          n_chk = 0, n_fail = 0;
    logic [15:0] sb_lfsr = 16'hACE1;
    int          m_rr = 0;
    int          dly = 3;
    bit          auto_on = 1'b1;
    int          cnt[N];
    logic [N-1:0] awaiting = '0;
    int          n_starts = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    bit          seen_first = 1'b0;
    int          mon_p;
    exp_t        mon_e;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic push_one(input logic [15:0] mask, input int prio);
        exp_t e;
        int   p;
        int   d;
        p = -1;
        for (int k = 0; k < N; k++) if (p < 0 && mask[(m_rr + k) % N]) p = (m_rr + k) % N;
        d      = int'(sb_lfsr[3:0]);
        e.port = p;
        e.dest = (d == p) ? (p + 1) % N : d;
        e.len  = 16 + int'(sb_lfsr[15:11]);
        e.prio = prio;
        sb.push_back(e);
        sb_lfsr = lfsr_step(sb_lfsr);
        m_rr    = (p + 1) % N;
    endtask

    task automatic go_pulse(input logic [15:0] t, input logic [2:0] p);
        @(negedge clk);
        cfg_total  = t;
        cfg_prio   = p;
        go         = 1'b1;
        seen_first = 1'b0;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_fin(output int c);
        c = 0;
        while (!finished && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("finished_reached", finished, 1);
    endtask

    // start monitor: checks every start against invariants and the scoreboard
    always @(posedge clk) begin
        #1;
        cyc++;
        if (send_start != '0) begin
            mon_p = 0;
            for (int k = N - 1; k >= 0; k--) if (send_start[k]) mon_p = k;
            chk("start_onehot", $countones(send_start), 1);
            chk("regrant_before_done", awaiting[mon_p], 0);
            chk("dest_not_self", int'(send_dest[mon_p*WS +: WS]) == mon_p, 0);
            chk("len_in_range", send_len[mon_p*WL +: WL] >= 16 && send_len[mon_p*WL +: WL] <= 47, 1);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_start: port %0d started, no start expected", mon_p);
            end else begin
                mon_e = sb.pop_front();
                chk("start_port", mon_p, mon_e.port);
                chk("start_dest", send_dest[mon_p*WS +: WS], mon_e.dest);
                chk("start_len", send_len[mon_p*WL +: WL], mon_e.len);
                chk("start_prio", send_prio[mon_p*WP +: WP], mon_e.prio);
            end
            n_starts++;
            if (!seen_first) first_cyc = cyc;
            seen_first = 1'b1;
            last_cyc   = cyc;
        end
        awaiting = (awaiting & ~send_done) | send_start;
    end

    // emulated send_modules: done pulse a fixed delay after each start
    always @(negedge clk) begin
        auto_done_v = '0;
        for (int p = 0; p < N; p++) begin
            if (cnt[p] > 0) begin
                cnt[p]--;
                if (cnt[p] == 0) auto_done_v[p] = 1'b1;
            end
            if (auto_on && send_start[p]) cnt[p] = dly;
        end
    end

    initial begin
        int c, s0, i0;
        vecs[0] = '{total: 16'd32, prio: 3'd1, ready: 16'hFFFF, dly: 3, max_cyc: 60, span: 31};
        vecs[1] = '{total: 16'd4,  prio: 3'd3, ready: 16'h0004, dly: 5, max_cyc: 60, span: -1};
        vecs[2] = '{total: 16'd0,  prio: 3'd2, ready: 16'hFFFF, dly: 3, max_cyc: 2,  span: -1};
        vecs[3] = '{total: 16'd7,  prio: 3'd6, ready: 16'h00A5, dly: 1, max_cyc: 30, span: 6};
        for (int p = 0; p < N; p++) cnt[p] = 0;

        repeat (3) @(negedge clk);
        chk("rst_start", send_start, 0);
        chk("rst_dest", send_dest, 0);
        chk("rst_prio", send_prio, 0);
        chk("rst_len_zero", send_len == '0, 1);
        chk("rst_issued", issued, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            ready   = vecs[i].ready;
            dly     = vecs[i].dly;
            auto_on = 1'b1;
            for (int j = 0; j < int'(vecs[i].total); j++) push_one(vecs[i].ready, int'(vecs[i].prio));
            go_pulse(vecs[i].total, vecs[i].prio);
            wait_fin(c);
            chk("vec_done_cycles_ok", c <= vecs[i].max_cyc, 1);
            chk("vec_issued", issued, vecs[i].total);
            chk("vec_outstanding", outstanding, 0);
            chk("vec_busy", busy, 0);
            chk("vec_sb_empty", sb.size(), 0);
            if (vecs[i].span >= 0) chk("vec_one_per_cycle_span", last_cyc - first_cyc, vecs[i].span);
        end

        ready = 16'hFFFF;
        dly   = 3;
        for (int j = 0; j < 40; j++) push_one(16'hFFFF, 5);
        go_pulse(16'd40, 3'd5);
        c = 0;
        while (issued != 16'd10 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("throttle_reach_10", issued, 10);
        alm = 1'b1;
        s0  = n_starts;
        i0  = int'(issued);
        repeat (20) begin
            @(negedge clk);
            chk("throttle_issued_frozen", issued, i0);
        end
        chk("throttle_no_starts", n_starts, s0);
        alm = 1'b0;
        @(negedge clk);
        chk("throttle_resume_next_cycle", n_starts, s0 + 1);
        wait_fin(c);
        chk("throttle_issued", issued, 40);
        chk("throttle_sb_empty", sb.size(), 0);

        auto_on  = 1'b0;
        ready    = 16'h0001;
        man_done = '0;
        push_one(16'h0001, 7);
        push_one(16'h0003, 7);
        push_one(16'h0003, 7);
        s0 = n_starts;
        go_pulse(16'd3, 3'd7);
        @(negedge clk);
        chk("sc_first_start", n_starts - s0, 1);
        chk("sc_out_1", outstanding, 1);
        ready    = 16'h0003;
        man_done = 16'h0001;
        @(negedge clk);
        man_done = '0;
        chk("same_cycle_grant_done_outstanding", outstanding, 1);
        chk("sc_issued_2", issued, 2);
        @(negedge clk);
        chk("sc_issued_3", issued, 3);
        chk("sc_out_2", outstanding, 2);
        chk("sc_drain_busy", busy, 1);
        man_done = 16'h0020;
        @(negedge clk);
        man_done = '0;
        chk("surplus_done_ignored", outstanding, 2);
        man_done = 16'h0002;
        @(negedge clk);
        man_done = '0;
        chk("drain_out_1", outstanding, 1);
        chk("drain_not_done_early", finished, 0);
        man_done = 16'h0001;
        @(negedge clk);
        man_done = '0;
        chk("drain_out_0", outstanding, 0);
        chk("done_lags_zero_by_one", finished, 0);
        @(negedge clk);
        chk("drain_to_done", finished, 1);
        chk("sc_sb_empty", sb.size(), 0);

        auto_on = 1'b1;
        dly     = 30;
        ready   = 16'hFFFF;
        for (int j = 0; j < 5; j++) push_one(16'hFFFF, 4);
        s0 = n_starts;
        go_pulse(16'd20, 3'd4);
        c = 0;
        while (n_starts < s0 + 5 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("abort_five_starts", n_starts - s0, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_finished", finished, 0);
        chk("abort_issued_hold", issued, 5);
        chk("abort_outstanding", outstanding, 5);
        c = 0;
        while (outstanding != 16'd0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("abort_outstanding_drains", outstanding, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_sixth_start", n_starts - s0, 5);
        chk("abort_sb_empty", sb.size(), 0);
        chk("abort_stays_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/send_scheduler.md
# send_scheduler

Round-robin traffic scheduler for the per-port `send_module` packet generators that feed `top_nxn`. Once `go` is pulsed, it issues `cfg_pkt_total` packet-start commands across the ports:

- Each command carries a pseudo-random destination (never the source port), a programmed priority and a pseudo-random length.
- Issuing throttles on `alm_ost_full` and `full`.
- After the last command, the block waits until every outstanding packet has reported `done`.

It replaces hand-written per-port stimulus and sits between the control/test logic and the `send_module` array.

## Interface
Parameters:
- `PORT_NUB_TOTAL`, 16: number of ports, power of two, ≥2.
- `WIDTH_SEL`, $clog2(PORT_NUB_TOTAL): port index width.
- `WIDTH_PRIORITY`, 3: priority field width.
- `WIDTH_LENGTH`, 10: length field width.
- `LEN_MIN`, 16: minimum packet length.
- `LEN_RAND_BITS`, 5: random length span is 2^LEN_RAND_BITS values; LEN_MIN + 2^LEN_RAND_BITS − 1 must fit in WIDTH_LENGTH.
- `SEED`, 16'hACE1: LFSR seed; 0 is replaced by 16'hACE1.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous active-low reset.
- `go` input 1: one-cycle start pulse; honoured in IDLE and DONE only.
- `abort` input 1: forces IDLE from any state.
- `cfg_pkt_total` input 16: number of packets to issue; sampled on `go`.
- `cfg_priority` input WIDTH_PRIORITY: priority for all packets; sampled on `go`.
- `full` input 1: switch buffer full.
- `alm_ost_full` input 1: switch buffer almost full.
- `send_ready` input PORT_NUB_TOTAL: per-port `send_module` ready.
- `send_done` input PORT_NUB_TOTAL: per-port one-cycle done pulse.
- `send_start` output PORT_NUB_TOTAL: per-port one-cycle start pulse.
- `send_dest` output PORT_NUB_TOTAL*WIDTH_SEL: destination per port; port i occupies bits [(i+1)*WIDTH_SEL−1 : i*WIDTH_SEL].
- `send_priority` output PORT_NUB_TOTAL*WIDTH_PRIORITY: priority per port, same packing.
- `send_length` output PORT_NUB_TOTAL*WIDTH_LENGTH: length per port, same packing.
- `issued_cnt` output 16: packets issued since the last `go`.
- `outstanding` output 16: packets started but not yet done.
- `busy` output 1: high in RUN or DRAIN.
- `finished` output 1: high in DONE.

## Operation
States: IDLE, RUN, DRAIN, DONE.

Transitions:
- IDLE/DONE + `go`:
  - Latch `cfg_pkt_total` and `cfg_priority`.
  - Clear `issued_cnt`.
  - Go to RUN, or to DRAIN if `cfg_pkt_total` = 0.
- RUN → DRAIN in the cycle after the grant that makes `issued_cnt` equal to the total.
- DRAIN → DONE when `outstanding` = 0.
- `abort` (any state) → IDLE next edge.
  - `abort` has priority over `go`.
  - No further starts are issued.
  - `outstanding` and `pending` keep tracking `send_done`.
  - All other registers hold.

Eligibility and grant:
- A port is eligible when `send_ready[i]` & ~`pending[i]`.
- `pending[i]` is set on grant and cleared on `send_done[i]`; a simultaneous set and clear leaves it set.
- In RUN, with `full` = 0, `alm_ost_full` = 0 and `issued_cnt` < total, at most one port is granted per cycle.
- The grant is the first eligible port scanning upward from `rr_ptr`, with wrap-around.
- After a grant, `rr_ptr` ← granted index + 1 (mod PORT_NUB_TOTAL). `rr_ptr` resets to 0 and is not cleared by `go`.

On a grant to port g, with `lfsr` the current value:
- Destination: `d` = `lfsr[WIDTH_SEL−1:0]`. If `d` = g, dest = (g+1) mod PORT_NUB_TOTAL; otherwise dest = `d`.
- Length: LEN_MIN + `lfsr[15:16−LEN_RAND_BITS]`.
- Priority: the latched `cfg_priority`.
- Field update: only port g's dest/priority/length fields are written. They hold until g's next grant.

LFSR:
- 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
- Advances once per grant only.
- Reset to SEED; not reseeded by `go`.

Counters:
- `outstanding` increments on a grant and decrements by popcount(`send_done`).
- Both may occur in one cycle.
- It never goes below 0; surplus `send_done` pulses from ports not pending are ignored.
- `issued_cnt` saturates at the latched total.

## Timing
- Reset values:
  - State IDLE.
  - All `send_start`, `send_dest`, `send_priority`, `send_length` = 0.
  - `issued_cnt` = 0, `outstanding` = 0, `pending` = 0.
  - `busy` = 0, `finished` = 0.
  - `lfsr` = SEED.
- Grant decision is made from inputs sampled at edge k. `send_start[g]` is registered high during cycle k..k+1 for exactly one cycle, with its fields already valid in that cycle.
- `go` sampled at edge k → RUN from k; the earliest `send_start` follows at edge k+1.
- `alm_ost_full` or `full` high at edge k means no grant at k. Throttle latency is 1 cycle.
- The `outstanding` = 0 check in DRAIN uses the registered value. DONE is entered one edge after `outstanding` reaches 0.
- `busy` and `finished` are decoded from the registered state.

## Test plan
- Reset, all `send_ready` = 1, `go` with total 32 and priority 1 → exactly 32 `send_start` pulses on ports 0,1,…,15,0,… (one per cycle while each port's `send_done` returns in time). No start has dest equal to its own index. All lengths lie in 16..47. All priorities = 1.
- Hold `alm_ost_full` = 1 for 20 cycles mid-RUN → zero starts during the window; issuing resumes the cycle after release. `issued_cnt` is frozen during the window.
- `send_ready` = 16'h0004 only → every grant goes to port 2. After each start, no re-grant until `send_done[2]` pulses.
- `go` with total 0 → DONE within 2 cycles; no starts issued.
- Grant and `send_done` on the same cycle → `outstanding` unchanged. DRAIN → DONE only after the final `send_done`.
- `abort` in RUN after 5 starts → no sixth start. IDLE is entered next edge. `outstanding` still decrements to 0 as the 5 dones arrive.
